// File: rtl/thor2024_macro_expander_pkg.sv
// Shared types for the Thor2024 macro expander: macro/uop encodings and
// default architectural register numbers.
package thor2024_macro_expander_pkg;

    localparam int REGW_DEF  = 6;
    localparam int SP_DEF    = 63;
    localparam int FP_DEF    = 62;
    localparam int LR_DEF    = 61;
    localparam int WORDB_DEF = 8;

    typedef enum logic [1:0] {
        OP_PUSH  = 2'd0,
        OP_POP   = 2'd1,
        OP_ENTER = 2'd2,
        OP_LEAVE = 2'd3
    } macro_op_t;

    typedef enum logic [1:0] {
        UOP_ADDI  = 2'd0,
        UOP_STORE = 2'd1,
        UOP_LOAD  = 2'd2
    } uop_kind_t;

    typedef struct packed {
        macro_op_t                      op;
        logic [2:0]                     cnt;
        logic [3:0][REGW_DEF-1:0]       regs;
        logic [15:0]                    imm;
        logic [63:0]                    pc;
    } macro_t;

    typedef struct packed {
        uop_kind_t                      kind;
        logic [REGW_DEF-1:0]            rd;
        logic [REGW_DEF-1:0]            rs;
        logic [REGW_DEF-1:0]            rs2;
        logic [63:0]                    imm;
        logic                           last;
        logic [63:0]                    pc;
    } uop_t;

    // Register lists hold at most four entries; larger counts saturate.
    function automatic logic [2:0] clamp_cnt(input logic [2:0] cnt);
        return (cnt > 3'd4) ? 3'd4 : cnt;
    endfunction

endpackage

// File: rtl/thor2024_macro_uop_gen.sv
// Combinational micro-op generator: maps a latched macro plus step index
// to the micro-op emitted at that step.
module thor2024_macro_uop_gen
    import thor2024_macro_expander_pkg::*;
#(
    parameter int SP_REG = SP_DEF,
    parameter int FP_REG = FP_DEF,
    parameter int LR_REG = LR_DEF,
    parameter int WORDB  = WORDB_DEF
) (
    input  macro_t     mac,
    input  logic [2:0] step,
    output uop_t       uop
);

    localparam logic [REGW_DEF-1:0] SP = REGW_DEF'(SP_REG);
    localparam logic [REGW_DEF-1:0] FP = REGW_DEF'(FP_REG);
    localparam logic [REGW_DEF-1:0] LR = REGW_DEF'(LR_REG);
    localparam logic [63:0]         WB = 64'(WORDB);

    logic [2:0]  n;
    logic [2:0]  sm1;
    logic [63:0] nbytes;

    always_comb begin
        n      = clamp_cnt(mac.cnt);
        sm1    = step - 3'd1;
        nbytes = WB * 64'(n);
        uop      = '0;
        uop.kind = UOP_ADDI;
        uop.pc   = mac.pc;
        case (mac.op)
            OP_PUSH: begin
                if (n == 3'd0) begin
                    uop.rd   = SP;
                    uop.rs   = SP;
                    uop.last = 1'b1;
                end else if (step == 3'd0) begin
                    uop.rd  = SP;
                    uop.rs  = SP;
                    uop.imm = 64'd0 - nbytes;
                end else begin
                    // Store i = step-1 lands at WORDB*(n-1-i) = WORDB*(n-step).
                    uop.kind = UOP_STORE;
                    uop.rs   = SP;
                    uop.rs2  = mac.regs[sm1[1:0]];
                    uop.imm  = WB * (64'(n) - 64'(step));
                    uop.last = (step == n);
                end
            end
            OP_POP: begin
                if (n == 3'd0) begin
                    uop.rd   = SP;
                    uop.rs   = SP;
                    uop.last = 1'b1;
                end else if (step < n) begin
                    uop.kind = UOP_LOAD;
                    uop.rd   = mac.regs[step[1:0]];
                    uop.rs   = SP;
                    uop.imm  = WB * 64'(step);
                end else begin
                    uop.rd   = SP;
                    uop.rs   = SP;
                    uop.imm  = nbytes;
                    uop.last = 1'b1;
                end
            end
            OP_ENTER: begin
                case (step)
                    3'd0: begin
                        uop.kind = UOP_STORE;
                        uop.rs   = SP;
                        uop.rs2  = FP;
                        uop.imm  = 64'd0 - 64'd16;
                    end
                    3'd1: begin
                        uop.kind = UOP_STORE;
                        uop.rs   = SP;
                        uop.rs2  = LR;
                        uop.imm  = 64'd0 - 64'd8;
                    end
                    3'd2: begin
                        uop.rd  = FP;
                        uop.rs  = SP;
                        uop.imm = 64'd0 - 64'd16;
                    end
                    default: begin
                        uop.rd   = SP;
                        uop.rs   = SP;
                        uop.imm  = 64'd0 - (64'd16 + 64'(mac.imm));
                        uop.last = 1'b1;
                    end
                endcase
            end
            OP_LEAVE: begin
                case (step)
                    3'd0: begin
                        uop.rd = SP;
                        uop.rs = FP;
                    end
                    3'd1: begin
                        uop.kind = UOP_LOAD;
                        uop.rd   = FP;
                        uop.rs   = SP;
                    end
                    3'd2: begin
                        uop.kind = UOP_LOAD;
                        uop.rd   = LR;
                        uop.rs   = SP;
                        uop.imm  = 64'd8;
                    end
                    default: begin
                        uop.rd   = SP;
                        uop.rs   = SP;
                        uop.imm  = 64'd16;
                        uop.last = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/thor2024_macro_expander.sv
// Macro expander between decode and rename: sequences PUSH/POP/ENTER/LEAVE
// into micro-ops. Define THOR2024_MACRO_B2B_EN for bubble-free macro chaining.
module thor2024_macro_expander
    import thor2024_macro_expander_pkg::*;
#(
    parameter int REGW   = REGW_DEF,
    parameter int SP_REG = SP_DEF,
    parameter int FP_REG = FP_DEF,
    parameter int LR_REG = LR_DEF,
    parameter int WORDB  = WORDB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_cnt,
    input  logic [4*REGW-1:0] in_regs,
    input  logic [15:0]       in_imm,
    input  logic [63:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [REGW-1:0]   out_rd,
    output logic [REGW-1:0]   out_rs,
    output logic [REGW-1:0]   out_rs2,
    output logic [63:0]       out_imm,
    output logic              out_last,
    output logic [63:0]       out_pc
);

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t     state;
    macro_t     mac_p0;
    logic [2:0] step_p0;
    uop_t       uop_p1;
    logic       vld_p1;

    macro_t     in_mac;
    macro_t     gen_mac;
    logic [2:0] gen_step;
    uop_t       gen_uop;
    logic       fire_out;
    logic       done;
    logic       accept;

    assign in_mac.op   = macro_op_t'(in_op);
    assign in_mac.cnt  = in_cnt;
    assign in_mac.regs = in_regs;
    assign in_mac.imm  = in_imm;
    assign in_mac.pc   = in_pc;

    assign fire_out = vld_p1 & out_ready;
    assign done     = fire_out & uop_p1.last;

`ifdef THOR2024_MACRO_B2B_EN
    assign in_ready = !flush && ((state == S_IDLE) || done);
`else
    assign in_ready = !flush && (state == S_IDLE);
`endif

    assign accept = in_valid & in_ready;

    // A newly accepted macro bypasses the latch so its first uop is ready next cycle.
    assign gen_mac  = accept ? in_mac : mac_p0;
    assign gen_step = accept ? 3'd0 : step_p0 + 3'd1;

    thor2024_macro_uop_gen #(
        .SP_REG (SP_REG),
        .FP_REG (FP_REG),
        .LR_REG (LR_REG),
        .WORDB  (WORDB)
    ) u_gen (
        .mac  (gen_mac),
        .step (gen_step),
        .uop  (gen_uop)
    );

    // p0: latched macro and step; p1: registered uop presented downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            mac_p0  <= '0;
            step_p0 <= 3'd0;
            uop_p1  <= '0;
            vld_p1  <= 1'b0;
        end else if (flush) begin
            state       <= S_IDLE;
            vld_p1      <= 1'b0;
            uop_p1.last <= 1'b0;
        end else if (accept) begin
            state   <= S_EXPAND;
            mac_p0  <= in_mac;
            step_p0 <= 3'd0;
            uop_p1  <= gen_uop;
            vld_p1  <= 1'b1;
        end else if (done) begin
            state       <= S_IDLE;
            vld_p1      <= 1'b0;
            uop_p1.last <= 1'b0;
        end else if (fire_out) begin
            step_p0 <= gen_step;
            uop_p1  <= gen_uop;
        end
    end

    assign out_valid = vld_p1;
    assign out_kind  = uop_p1.kind;
    assign out_rd    = uop_p1.rd;
    assign out_rs    = uop_p1.rs;
    assign out_rs2   = uop_p1.rs2;
    assign out_imm   = uop_p1.imm;
    assign out_last  = uop_p1.last;
    assign out_pc    = uop_p1.pc;

endmodule

// File: tb/tb_thor2024_macro_expander.sv
// Directed self-checking bench for thor2024_macro_expander (default and
// THOR2024_MACRO_B2B_EN builds).
module tb_thor2024_macro_expander;

    localparam logic [1:0] K_ADDI = 2'd0, K_STORE = 2'd1, K_LOAD = 2'd2;
    localparam logic [1:0] M_PUSH = 2'd0, M_POP = 2'd1, M_ENTER = 2'd2, M_LEAVE = 2'd3;
    localparam logic [5:0] SP = 6'd63, FP = 6'd62, LR = 6'd61, R0 = 6'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_cnt;
    logic [23:0] in_regs;
    logic [15:0] in_imm;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [5:0]  out_rd;
    logic [5:0]  out_rs;
    logic [5:0]  out_rs2;
    logic [63:0] out_imm;
    logic        out_last;
    logic [63:0] out_pc;

    int asserts = 0;
    int fails   = 0;

    thor2024_macro_expander dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_cnt    (in_cnt),
        .in_regs   (in_regs),
        .in_imm    (in_imm),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_rd    (out_rd),
        .out_rs    (out_rs),
        .out_rs2   (out_rs2),
        .out_imm   (out_imm),
        .out_last  (out_last),
        .out_pc    (out_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [148:0] mk(input logic [1:0] kind, input logic [5:0] rd,
                                        input logic [5:0] rs, input logic [5:0] rs2,
                                        input logic [63:0] imm, input logic last,
                                        input logic [63:0] pc);
        return {kind, rd, rs, rs2, imm, last, pc};
    endfunction

    function automatic logic [148:0] act();
        return {out_kind, out_rd, out_rs, out_rs2, out_imm, out_last, out_pc};
    endfunction

    // Present a macro and hold it until accepted; returns 1ns after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [23:0] regs,
                         input logic [15:0] imm, input logic [63:0] pc);
        int w;
        @(negedge clk);
        in_op = op; in_cnt = cnt; in_regs = regs; in_imm = imm; in_pc = pc;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            asserts++; fails++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        asserts++;
        if ({out_valid, out_last, in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL reset_ctrl: valid/last/ready=%b required 001", {out_valid, out_last, in_ready});
        end
        asserts++;
        if (act() !== '0) begin
            fails++;
            $display("FAIL reset_data: got %h required 0", act());
        end
        rst = 1'b0;
    endtask

    task automatic test_push3();
        logic [148:0] exp [4];
        exp[0] = mk(K_ADDI,  SP, SP, R0,   -64'sd24, 1'b0, 64'h1000);
        exp[1] = mk(K_STORE, R0, SP, 6'd5, 64'd16,   1'b0, 64'h1000);
        exp[2] = mk(K_STORE, R0, SP, 6'd6, 64'd8,    1'b0, 64'h1000);
        exp[3] = mk(K_STORE, R0, SP, 6'd7, 64'd0,    1'b1, 64'h1000);
        out_ready = 1'b1;
        issue(M_PUSH, 3'd3, {6'd0, 6'd7, 6'd6, 6'd5}, 16'd0, 64'h1000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            asserts++;
            if ({out_valid, act()} !== {1'b1, exp[k]}) begin
                fails++;
                $display("FAIL push3_uop%0d: got %b/%h required 1/%h", k, out_valid, act(), exp[k]);
            end
            if (k == 0) begin
                asserts++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL push3_busy_ready: got %b required 0", in_ready);
                end
            end
        end
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL push3_end_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_pop2_stall();
        logic [148:0] exp [3];
        exp[0] = mk(K_LOAD, 6'd9,  SP, R0, 64'd0,  1'b0, 64'h2000);
        exp[1] = mk(K_LOAD, 6'd10, SP, R0, 64'd8,  1'b0, 64'h2000);
        exp[2] = mk(K_ADDI, SP,    SP, R0, 64'd16, 1'b1, 64'h2000);
        out_ready = 1'b0;
        issue(M_POP, 3'd2, {6'd0, 6'd0, 6'd10, 6'd9}, 16'd0, 64'h2000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            asserts++;
            if ({out_valid, act()} !== {1'b1, exp[k]}) begin
                fails++;
                $display("FAIL pop2_uop%0d: got %b/%h required 1/%h", k, out_valid, act(), exp[k]);
            end
            out_ready = 1'b0;
            @(negedge clk);
            asserts++;
            if ({out_valid, act()} !== {1'b1, exp[k]}) begin
                fails++;
                $display("FAIL pop2_hold%0d: got %b/%h required 1/%h", k, out_valid, act(), exp[k]);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL pop2_end_valid: got %b required 0", out_valid);
        end
    endtask

    task automatic test_enter_leave();
        logic [148:0] exp [8];
        exp[0] = mk(K_STORE, R0, SP, FP, -64'sd16, 1'b0, 64'h3000);
        exp[1] = mk(K_STORE, R0, SP, LR, -64'sd8,  1'b0, 64'h3000);
        exp[2] = mk(K_ADDI,  FP, SP, R0, -64'sd16, 1'b0, 64'h3000);
        exp[3] = mk(K_ADDI,  SP, SP, R0, -64'sd48, 1'b1, 64'h3000);
        exp[4] = mk(K_ADDI,  SP, FP, R0, 64'd0,    1'b0, 64'h3040);
        exp[5] = mk(K_LOAD,  FP, SP, R0, 64'd0,    1'b0, 64'h3040);
        exp[6] = mk(K_LOAD,  LR, SP, R0, 64'd8,    1'b0, 64'h3040);
        exp[7] = mk(K_ADDI,  SP, SP, R0, 64'd16,   1'b1, 64'h3040);
        out_ready = 1'b1;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) issue(M_ENTER, 3'd0, 24'd0, 16'd32, 64'h3000);
            else        issue(M_LEAVE, 3'd0, 24'd0, 16'd0,  64'h3040);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                asserts++;
                if ({out_valid, act()} !== {1'b1, exp[4*m+k]}) begin
                    fails++;
                    $display("FAIL enter_leave_uop%0d: got %b/%h required 1/%h", 4*m+k, out_valid, act(), exp[4*m+k]);
                end
            end
        end
    endtask

    task automatic test_push_cnt_bounds();
        logic [148:0] exp [5];
        out_ready = 1'b1;
        issue(M_PUSH, 3'd0, {6'd4, 6'd3, 6'd2, 6'd1}, 16'd0, 64'h4000);
        @(negedge clk);
        asserts++;
        if ({out_valid, act()} !== {1'b1, mk(K_ADDI, SP, SP, R0, 64'd0, 1'b1, 64'h4000)}) begin
            fails++;
            $display("FAIL push0_uop: got %b/%h required single ADDI sp,sp,0 last", out_valid, act());
        end
        exp[0] = mk(K_ADDI,  SP, SP, R0,   -64'sd32, 1'b0, 64'h4100);
        exp[1] = mk(K_STORE, R0, SP, 6'd1, 64'd24,   1'b0, 64'h4100);
        exp[2] = mk(K_STORE, R0, SP, 6'd2, 64'd16,   1'b0, 64'h4100);
        exp[3] = mk(K_STORE, R0, SP, 6'd3, 64'd8,    1'b0, 64'h4100);
        exp[4] = mk(K_STORE, R0, SP, 6'd4, 64'd0,    1'b1, 64'h4100);
        issue(M_PUSH, 3'd7, {6'd4, 6'd3, 6'd2, 6'd1}, 16'd0, 64'h4100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            asserts++;
            if ({out_valid, act()} !== {1'b1, exp[k]}) begin
                fails++;
                $display("FAIL push7_uop%0d: got %b/%h required 1/%h", k, out_valid, act(), exp[k]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        issue(M_PUSH, 3'd4, {6'd4, 6'd3, 6'd2, 6'd1}, 16'd0, 64'h5000);
        @(negedge clk);
        @(negedge clk);
        asserts++;
        if ({out_valid, act()} !== {1'b1, mk(K_STORE, R0, SP, 6'd1, 64'd24, 1'b0, 64'h5000)}) begin
            fails++;
            $display("FAIL flush_pre_uop: got %b/%h required STORE r1@24", out_valid, act());
        end
        flush = 1'b1;
        in_op = M_POP; in_cnt = 3'd1; in_regs = {18'd0, 6'd9}; in_pc = 64'h5100;
        in_valid = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        asserts++;
        if ({out_valid, out_last, in_ready} !== 3'b001) begin
            fails++;
            $display("FAIL flush_idle: valid/last/ready=%b required 001", {out_valid, out_last, in_ready});
        end
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_drop: got %b required 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(M_PUSH, 3'd2, {12'd0, 6'd2, 6'd1}, 16'd0, 64'h6000);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        asserts++;
        if ({out_valid, in_ready, out_imm} !== {1'b0, 1'b1, 64'd0}) begin
            fails++;
            $display("FAIL reset_mid: valid/ready/imm=%b/%b/%h required 0/1/0", out_valid, in_ready, out_imm);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        asserts++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_after: got %b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic         v   [6];
        logic [148:0] u   [6];
        logic         ev  [6];
        logic [148:0] eu  [6];
        logic [148:0] p0, p1, q0, q1;
        p0 = mk(K_ADDI,  SP,   SP, R0,   -64'sd8, 1'b0, 64'h7000);
        p1 = mk(K_STORE, R0,   SP, 6'd3, 64'd0,   1'b1, 64'h7000);
        q0 = mk(K_LOAD,  6'd4, SP, R0,   64'd0,   1'b0, 64'h7100);
        q1 = mk(K_ADDI,  SP,   SP, R0,   64'd8,   1'b1, 64'h7100);
`ifdef THOR2024_MACRO_B2B_EN
        ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        eu = '{p0, p1, q0, q1, '0, '0};
`else
        ev = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        eu = '{p0, p1, '0, q0, q1, '0};
`endif
        out_ready = 1'b1;
        issue(M_PUSH, 3'd1, {18'd0, 6'd3}, 16'd0, 64'h7000);
        @(negedge clk);
        v[0] = out_valid;
        u[0] = act();
        in_op = M_POP; in_cnt = 3'd1; in_regs = {18'd0, 6'd4}; in_imm = 16'd0; in_pc = 64'h7100;
        in_valid = 1'b1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            v[c] = out_valid;
            u[c] = act();
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            asserts++;
            if (ev[c] ? ({v[c], u[c]} !== {1'b1, eu[c]}) : (v[c] !== 1'b0)) begin
                fails++;
                $display("FAIL b2b_cycle%0d: got %b/%h required %b/%h", c, v[c], u[c], ev[c], eu[c]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 2'd0; in_cnt = 3'd0; in_regs = 24'd0; in_imm = 16'd0; in_pc = 64'd0;
        test_reset();
        test_push3();
        test_pop2_stall();
        test_enter_leave();
        test_push_cnt_bounds();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
